// File: rtl/bcim_pkg.sv
// Shared types and constants for the bitline compute-in-memory row-op blocks.
package bcim_pkg;

  // Row operation codes as carried on the command interface.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } bcim_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } bcim_state_e;

  // Cycles from a command's accept cycle to its done cycle; also the command spacing.
  localparam int unsigned BCIM_SEQ_LATENCY = 4;

endpackage

// File: rtl/bcim_row_alu.sv
// Combinational row-wide ALU: f(op, a, b) -> {carry, result}.
// carry is the bit above the word for ADD and 0 for all logic ops.
module bcim_row_alu
  import bcim_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  bcim_op_e              op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry
);

  logic [DATA_WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // Select the row operation; ADD wraps modulo 2^DATA_WIDTH with carry exposed separately.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        result = sum[DATA_WIDTH-1:0];
        carry  = sum[DATA_WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bcim_row_op_seq.sv
// Row-op sequencer in front of the dual-port bitline RAM: reads two rows via
// ports A/B, computes a row-wide result and writes it back through port A.
// Optional macro BCIM_CARRY_OUT_EN adds a carry_out port for ADD.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a command; done pulses in the first IDLE cycle
//   READ  | RAM samples address_a/address_b at the end of this cycle
//   EXEC  | q_a/q_b valid; result, write data and dst address loaded
//   WRITE | wren_a high; RAM commits the result at the end of this cycle
module bcim_row_op_seq
  import bcim_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src_a,
  input  logic [ADDR_WIDTH-1:0] cmd_src_b,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] address_a,
  output logic [ADDR_WIDTH-1:0] address_b,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  wren_a,
  output logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] q_b
`ifdef BCIM_CARRY_OUT_EN
  ,
  output logic                  carry_out
`endif
);

  bcim_state_e           state, state_nxt;
  bcim_op_e              op_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Port B is read-only.
  assign data_b = '0;
  assign wren_b = 1'b0;

  bcim_row_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op    (op_q),
    .a     (q_a),
    .b     (q_b),
    .result(alu_result),
    .carry (alu_carry)
  );

`ifndef BCIM_CARRY_OUT_EN
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: fixed four-cycle walk once a command is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered RAM-side outputs, command latches, result and done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_a <= '0;
      address_b <= '0;
      data_a    <= '0;
      wren_a    <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      op_q      <= OP_AND;
      dst_q     <= '0;
`ifdef BCIM_CARRY_OUT_EN
      carry_out <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            address_a <= cmd_src_a;
            address_b <= cmd_src_b;
            op_q      <= bcim_op_e'(cmd_op);
            dst_q     <= cmd_dst;
          end
        end
        EXEC: begin
          result    <= alu_result;
          data_a    <= alu_result;
          address_a <= dst_q;
          wren_a    <= 1'b1;
`ifdef BCIM_CARRY_OUT_EN
          carry_out <= alu_carry;
`endif
        end
        WRITE: begin
          wren_a <= 1'b0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
